tag_lookup_proc: RTL



---
 rtl/tag_lookup_proc.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/tag_lookup_proc.sv
// Processor-side tag lookup: 4-way tag/valid store with hit/miss resolution,
// victim selection, line fill handshake and a one-cycle completion strobe.
module tag_lookup_proc #(
  parameter int unsigned ASSOC      = 4,
  parameter int unsigned INDEX_MSB  = 19,
  parameter int unsigned INDEX_LSB  = 2,
  parameter int unsigned TAG_MSB    = 31,
  parameter int unsigned TAG_LSB    = 20,
  parameter int unsigned OFFSET_MSB = 1,
  parameter int unsigned OFFSET_LSB = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_rd,
  input  logic                                cmd_wr,
  input  logic [INDEX_MSB-INDEX_LSB:0]        index_proc,
  input  logic [TAG_MSB-TAG_LSB:0]            tag_proc,
  input  logic [OFFSET_MSB-OFFSET_LSB:0]      blk_offset_proc,
  input  logic                                fill_ack,
  output logic                                busy,
  output logic                                fill_req,
  output logic [1:0]                          fill_way,
  output logic [INDEX_MSB-INDEX_LSB:0]        fill_index,
  output logic [TAG_MSB-TAG_LSB:0]            fill_tag,
  output logic                                done,
  output logic                                hit,
  output logic [1:0]                          hit_way,
  output logic                                resp_wr,
  output logic [OFFSET_MSB-OFFSET_LSB:0]      resp_offset
);

  localparam int unsigned IDX_W    = INDEX_MSB - INDEX_LSB + 1;
  localparam int unsigned TAG_W    = TAG_MSB - TAG_LSB + 1;
  localparam int unsigned OFF_W    = OFFSET_MSB - OFFSET_LSB + 1;
  localparam int unsigned WAY_W    = 2;
  localparam int unsigned NUM_SETS = 2 ** IDX_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_WAIT = 3'd2,
    RESP      = 3'd3,
    RELEASE   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [IDX_W-1:0]   req_index_q, req_index_d;
  logic [OFF_W-1:0]   req_off_q, req_off_d;
  logic               req_wr_q, req_wr_d;
  logic               busy_q, busy_d;
  logic               fill_req_q, fill_req_d;
  logic [WAY_W-1:0]   fill_way_q, fill_way_d;
  logic [IDX_W-1:0]   fill_index_q, fill_index_d;
  logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
  logic               done_q, done_d;
  logic               hit_q, hit_d;
  logic [WAY_W-1:0]   hit_way_q, hit_way_d;
  logic               resp_wr_q, resp_wr_d;
  logic [OFF_W-1:0]   resp_offset_q, resp_offset_d;

  logic [ASSOC-1:0]   valid_q [NUM_SETS];
  logic [WAY_W-1:0]   rr_q    [NUM_SETS];
  logic [TAG_W-1:0]   tag_q   [NUM_SETS][ASSOC];

  logic [ASSOC-1:0]   set_valid_c;
  logic [ASSOC-1:0]   match_c;
  logic [WAY_W-1:0]   match_way_c;
  logic [WAY_W-1:0]   victim_c;
  logic               fill_we_c;

  // Compare latched tag against the latched set; lowest way wins on both searches
  always_comb begin
    set_valid_c = valid_q[req_index_q];
    match_way_c = '0;
    victim_c    = rr_q[req_index_q];
    for (int w = 0; w < int'(ASSOC); w++) begin
      match_c[w] = set_valid_c[w] && (tag_q[req_index_q][w] == req_tag_q);
    end
    for (int w = int'(ASSOC) - 1; w >= 0; w--) begin
      if (match_c[w])      match_way_c = WAY_W'(w);
      if (!set_valid_c[w]) victim_c    = WAY_W'(w);
    end
  end

  always_comb begin
    state_d       = state_q;
    req_tag_d     = req_tag_q;
    req_index_d   = req_index_q;
    req_off_d     = req_off_q;
    req_wr_d      = req_wr_q;
    fill_req_d    = fill_req_q;
    fill_way_d    = fill_way_q;
    fill_index_d  = fill_index_q;
    fill_tag_d    = fill_tag_q;
    done_d        = 1'b0;
    hit_d         = hit_q;
    hit_way_d     = hit_way_q;
    resp_wr_d     = resp_wr_q;
    resp_offset_d = resp_offset_q;
    fill_we_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_rd ^ cmd_wr) begin
          req_tag_d   = tag_proc;
          req_index_d = index_proc;
          req_off_d   = blk_offset_proc;
          req_wr_d    = cmd_wr;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (|match_c) begin
          state_d       = RESP;
          done_d        = 1'b1;
          hit_d         = 1'b1;
          hit_way_d     = match_way_c;
          resp_wr_d     = req_wr_q;
          resp_offset_d = req_off_q;
        end else begin
          state_d      = MISS_WAIT;
          fill_req_d   = 1'b1;
          fill_way_d   = victim_c;
          fill_index_d = req_index_q;
          fill_tag_d   = req_tag_q;
        end
      end
      MISS_WAIT: begin
        if (fill_ack) begin
          fill_we_c     = 1'b1;
          fill_req_d    = 1'b0;
          state_d       = RESP;
          done_d        = 1'b1;
          hit_d         = 1'b0;
          hit_way_d     = fill_way_q;
          resp_wr_d     = req_wr_q;
          resp_offset_d = req_off_q;
        end
      end
      RESP:    state_d = RELEASE;
      RELEASE: if (!cmd_rd && !cmd_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_tag_q     <= '0;
      req_index_q   <= '0;
      req_off_q     <= '0;
      req_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      fill_req_q    <= 1'b0;
      fill_way_q    <= '0;
      fill_index_q  <= '0;
      fill_tag_q    <= '0;
      done_q        <= 1'b0;
      hit_q         <= 1'b0;
      hit_way_q     <= '0;
      resp_wr_q     <= 1'b0;
      resp_offset_q <= '0;
    end else begin
      state_q       <= state_d;
      req_tag_q     <= req_tag_d;
      req_index_q   <= req_index_d;
      req_off_q     <= req_off_d;
      req_wr_q      <= req_wr_d;
      busy_q        <= busy_d;
      fill_req_q    <= fill_req_d;
      fill_way_q    <= fill_way_d;
      fill_index_q  <= fill_index_d;
      fill_tag_q    <= fill_tag_d;
      done_q        <= done_d;
      hit_q         <= hit_d;
      hit_way_q     <= hit_way_d;
      resp_wr_q     <= resp_wr_d;
      resp_offset_q <= resp_offset_d;
    end
  end

  // Valid bits and replacement pointers all clear together on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (fill_we_c) begin
      valid_q[fill_index_q][fill_way_q] <= 1'b1;
      rr_q[fill_index_q]                <= rr_q[fill_index_q] + WAY_W'(1);
    end
  end

  // Tag storage carries no reset; entries are qualified by valid_q
  always_ff @(posedge clk) begin
    if (fill_we_c && !rst) begin
      tag_q[fill_index_q][fill_way_q] <= fill_tag_q;
    end
  end

  assign busy        = busy_q;
  assign fill_req    = fill_req_q;
  assign fill_way    = fill_way_q;
  assign fill_index  = fill_index_q;
  assign fill_tag    = fill_tag_q;
  assign done        = done_q;
  assign hit         = hit_q;
  assign hit_way     = hit_way_q;
  assign resp_wr     = resp_wr_q;
  assign resp_offset = resp_offset_q;

endmodule
